// File: rtl/wb_regfile_if.sv
// Writeback-stage bus: MEM/WB beat in, decode read ports and WB/forwarding info out.
interface wb_regfile_if #(parameter int XLEN = 32);
    logic            mem_to_reg;
    logic            reg_write;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] alu_result;
    logic [31:0]     rd;
    logic [2:0]      load_funct3;
    logic            retire;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [63:0]     instret;

    modport master (
        output mem_to_reg, reg_write, mem_data, alu_result, rd, load_funct3,
               retire, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_en, wb_rd, wb_data, instret
    );

    modport slave (
        input  mem_to_reg, reg_write, mem_data, alu_result, rd, load_funct3,
               retire, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_en, wb_rd, wb_data, instret
    );
endinterface

// File: rtl/wb_regfile.sv
// RV32I writeback stage: load extraction, WB mux, 32x32 register file with
// write-through bypass on both read ports, and a 64-bit retired-instruction counter.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic         clk,
    input logic         reset,
    wb_regfile_if.slave bus
);
    logic [XLEN-1:0] r_regs [NREGS];
    logic [63:0]     r_instret;

    logic [1:0]      w_off;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_wb_data;
    logic [4:0]      w_rd;
    logic            w_wb_en;
    logic            w_unused;

    assign w_off    = bus.alu_result[1:0];
    assign w_rd     = bus.rd[4:0];
    assign w_unused = &{1'b0, bus.rd[31:5]};
    assign w_wb_en  = bus.reg_write && (w_rd != 5'd0);
    assign w_byte   = bus.mem_data[{w_off, 3'b000} +: 8];
    assign w_half   = bus.mem_data[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load = bus.mem_data;
        case (bus.load_funct3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = bus.mem_data;
        endcase
    end

    assign w_wb_data = bus.mem_to_reg ? w_load : bus.alu_result;

    // Bypass sits after the WB mux so a same-cycle write is visible to decode.
    always_comb begin
        bus.rs1_data = r_regs[bus.rs1_addr];
        if (bus.rs1_addr == 5'd0)
            bus.rs1_data = '0;
        else if (w_wb_en && (w_rd == bus.rs1_addr))
            bus.rs1_data = w_wb_data;
    end

    always_comb begin
        bus.rs2_data = r_regs[bus.rs2_addr];
        if (bus.rs2_addr == 5'd0)
            bus.rs2_data = '0;
        else if (w_wb_en && (w_rd == bus.rs2_addr))
            bus.rs2_data = w_wb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_instret <= '0;
        end else begin
            if (w_wb_en)
                r_regs[w_rd] <= w_wb_data;
            if (bus.retire)
                r_instret <= r_instret + 64'd1;
        end
    end

    assign bus.wb_en   = w_wb_en;
    assign bus.wb_rd   = w_rd;
    assign bus.wb_data = w_wb_data;
    assign bus.instret = r_instret;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized checks of wb_regfile against a behavioural model.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] m_regs [32];
  logic [63:0] m_instret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_wb();
    logic [31:0] byte_v, half_v;
    int off;
    off    = int'(bus.alu_result[1:0]);
    byte_v = (bus.mem_data >> (8 * off)) & 32'hFF;
    half_v = (bus.mem_data >> (16 * (off / 2))) & 32'hFFFF;
    if (!bus.mem_to_reg) return bus.alu_result;
    case (bus.load_funct3)
      3'b000:  return (byte_v >= 32'h80) ? byte_v - 32'd256 : byte_v;
      3'b100:  return byte_v;
      3'b001:  return (half_v >= 32'h8000) ? half_v - 32'd65536 : half_v;
      3'b101:  return half_v;
      default: return bus.mem_data;
    endcase
  endfunction

  function automatic logic ref_en();
    return bus.reg_write && ((bus.rd % 32) != 0);
  endfunction

  function automatic logic [31:0] ref_rs(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (ref_en() && (bus.rd % 32) == 32'(a)) return ref_wb();
    return m_regs[a];
  endfunction

  task automatic beat(input logic m2r, input logic rw, input logic [31:0] md,
                      input logic [31:0] alu, input logic [31:0] rdv, input logic [2:0] f3,
                      input logic ret, input logic [4:0] a1, input logic [4:0] a2);
    bus.mem_to_reg  = m2r;
    bus.reg_write   = rw;
    bus.mem_data    = md;
    bus.alu_result  = alu;
    bus.rd          = rdv;
    bus.load_funct3 = f3;
    bus.retire      = ret;
    bus.rs1_addr    = a1;
    bus.rs2_addr    = a2;
    #1;
  endtask

  task automatic bubble(input logic [4:0] a1, input logic [4:0] a2);
    beat(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, a1, a2);
  endtask

  // Advance one edge and apply the architectural rules to the model.
  task automatic tick();
    logic        en;
    logic [31:0] wd;
    int          idx;
    en  = ref_en();
    wd  = ref_wb();
    idx = int'(bus.rd % 32);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_instret = 64'd0;
    end else begin
      if (en) m_regs[idx] = wd;
      if (bus.retire) m_instret = m_instret + 64'd1;
    end
    #1;
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".rs1"}, 64'(bus.rs1_data), 64'(ref_rs(bus.rs1_addr)));
    check({tag, ".rs2"}, 64'(bus.rs2_data), 64'(ref_rs(bus.rs2_addr)));
    check({tag, ".wb_en"}, 64'(bus.wb_en), 64'(ref_en()));
    check({tag, ".wb_rd"}, 64'(bus.wb_rd), 64'(bus.rd % 32));
    if (bus.reg_write) check({tag, ".wb_data"}, 64'(bus.wb_data), 64'(ref_wb()));
  endtask

  initial begin
    logic [31:0] r_rd, r_alu, r_md;
    logic [4:0]  r_a1, r_a2;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'hX;
    m_instret = 64'hX;
    bubble(5'd0, 5'd0);

    // Reset then read every address on both ports
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bubble(5'(i), 5'(31 - i));
      check("rst.rs1", 64'(bus.rs1_data), 64'd0);
      check("rst.rs2", 64'(bus.rs2_data), 64'd0);
    end
    check("rst.instret", bus.instret, 64'd0);

    // ALU write with same-cycle bypass
    beat(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 32'd5, 3'd2, 1'b1, 5'd5, 5'd0);
    check("alu.bypass", 64'(bus.rs1_data), 64'hDEADBEEF);
    check("alu.wb_en", 64'(bus.wb_en), 64'd1);
    tick();
    bubble(5'd5, 5'd5);
    check("alu.stored", 64'(bus.rs1_data), 64'hDEADBEEF);
    check("alu.instret", bus.instret, 64'd1);

    // Write to x0 (also via ignored upper rd bits) is dropped
    beat(1'b0, 1'b1, 32'h0, 32'h12345678, 32'h0000_0020, 3'd2, 1'b1, 5'd0, 5'd0);
    check("x0.wb_en", 64'(bus.wb_en), 64'd0);
    check("x0.wb_rd", 64'(bus.wb_rd), 64'd0);
    tick();
    bubble(5'd0, 5'd0);
    check("x0.read", 64'(bus.rs1_data), 64'd0);

    // Load extraction, no write
    beat(1'b1, 1'b1, 32'h80F17F01, 32'h103, 32'd0, 3'b000, 1'b0, 5'd0, 5'd0);
    check("lb.off3", 64'(bus.wb_data), 64'hFFFFFF80);
    beat(1'b1, 1'b1, 32'h80F17F01, 32'h101, 32'd0, 3'b100, 1'b0, 5'd0, 5'd0);
    check("lbu.off1", 64'(bus.wb_data), 64'h0000007F);
    beat(1'b1, 1'b1, 32'h80F17F01, 32'h102, 32'd0, 3'b001, 1'b0, 5'd0, 5'd0);
    check("lh.off2", 64'(bus.wb_data), 64'hFFFF80F1);
    beat(1'b1, 1'b1, 32'h80F17F01, 32'h100, 32'd0, 3'b101, 1'b0, 5'd0, 5'd0);
    check("lhu.off0", 64'(bus.wb_data), 64'h00007F01);
    beat(1'b1, 1'b1, 32'h80F17F01, 32'h102, 32'd0, 3'b010, 1'b0, 5'd0, 5'd0);
    check("lw.off2", 64'(bus.wb_data), 64'h80F17F01);
    beat(1'b1, 1'b1, 32'h80F17F01, 32'h103, 32'd0, 3'b111, 1'b0, 5'd0, 5'd0);
    check("undef.f3", 64'(bus.wb_data), 64'h80F17F01);
    beat(1'b1, 1'b1, 32'h80F17F01, 32'h103, 32'd0, 3'b001, 1'b0, 5'd0, 5'd0);
    check("lh.off3", 64'(bus.wb_data), 64'hFFFF80F1);

    // Dual-port bypass priority
    beat(1'b0, 1'b1, 32'h0, 32'h11, 32'd7, 3'd0, 1'b0, 5'd0, 5'd0);
    tick();
    beat(1'b0, 1'b1, 32'h0, 32'h33, 32'd8, 3'd0, 1'b0, 5'd0, 5'd0);
    tick();
    beat(1'b0, 1'b1, 32'h0, 32'h22, 32'd7, 3'd0, 1'b0, 5'd7, 5'd7);
    check("dual.rs1", 64'(bus.rs1_data), 64'h22);
    check("dual.rs2", 64'(bus.rs2_data), 64'h22);
    beat(1'b0, 1'b1, 32'h0, 32'h22, 32'd7, 3'd0, 1'b0, 5'd7, 5'd8);
    check("dual.rs2_x8", 64'(bus.rs2_data), 64'h33);
    tick();
    bubble(5'd7, 5'd8);
    check("dual.x7", 64'(bus.rs1_data), 64'h22);

    // Retire counting from a clean reset: 10 retires (3 without write), 3 bubbles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i % 4 == 3) bubble(5'd0, 5'd0);
      else beat(1'b0, (i >= 3), 32'h0, 32'(i), 32'(i + 10), 3'd0, 1'b1, 5'd0, 5'd0);
      tick();
    end
    bubble(5'd0, 5'd0);
    check("retire.count", bus.instret, 64'd10);

    // Counter wrap
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    beat(1'b0, 1'b0, 32'h0, 32'h0, 32'd0, 3'd0, 1'b1, 5'd0, 5'd0);
    tick();
    m_instret = 64'd0;
    bubble(5'd0, 5'd0);
    check("retire.wrap", bus.instret, 64'd0);

    // Randomized beats against the model
    for (int n = 0; n < 400; n++) begin
      r_rd  = $urandom;
      r_alu = $urandom;
      r_md  = $urandom;
      r_a1  = ($urandom_range(0, 2) == 0) ? r_rd[4:0] : 5'($urandom_range(0, 31));
      r_a2  = ($urandom_range(0, 2) == 0) ? r_rd[4:0] : 5'($urandom_range(0, 31));
      reset = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) bubble(r_a1, r_a2);
      else beat(1'($urandom), 1'($urandom_range(0, 3) != 0), r_md, r_alu, r_rd,
                3'($urandom), 1'($urandom), r_a1, r_a2);
      check_comb("rand");
      tick();
      reset = 1'b0;
      check("rand.instret", bus.instret, m_instret);
    end

    // Reset mid-stream discards the in-flight write and retire
    beat(1'b0, 1'b1, 32'h0, 32'h55, 32'd3, 3'd0, 1'b1, 5'd0, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bubble(5'd3, 5'd3);
    check("midrst.x3", 64'(bus.rs1_data), 64'd0);
    check("midrst.instret", bus.instret, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
